// File: rtl/mpi_recv_buffer.sv
// Receive-side elastic FIFO behind the MPI receiver: yumi-handshake intake, source-rank filter, FWFT valid/ready output.
// Optional saturating statistics counters are built when MPI_RECV_BUFFER_STATS_EN is defined.
module mpi_recv_buffer #(
    parameter int DATA_W   = 64,
    parameter int ORIGIN_W = 32,
    parameter int DEPTH    = 8,
    parameter int CNT_W    = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    input  logic [DATA_W-1:0]          in_data,
    input  logic [ORIGIN_W-1:0]        in_origin,
    output logic                       in_yumi,
    input  logic [ORIGIN_W-1:0]        cfg_origin,
    input  logic                       cfg_any,
    output logic                       out_valid,
    output logic [DATA_W-1:0]          out_data,
    output logic [ORIGIN_W-1:0]        out_origin,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       full,
    output logic                       empty,
    output logic [CNT_W-1:0]           rx_count,
    output logic [CNT_W-1:0]           drop_count
);
    localparam int PTR_W   = $clog2(DEPTH);
    localparam int LVL_W   = PTR_W + 1;
    localparam int ENTRY_W = ORIGIN_W + DATA_W;

    logic [ENTRY_W-1:0]  mem_r [DEPTH];
    logic [PTR_W-1:0]    wr_ptr_r;
    logic [PTR_W-1:0]    rd_ptr_r;
    logic [LVL_W-1:0]    level_r;
    logic [LVL_W-1:0]    level_nxt_s;
    logic                full_r;
    logic                empty_r;
    logic                match_s;
    logic                push_s;
    logic                pop_s;
    logic [ENTRY_W-1:0]  head_s;

    assign match_s = cfg_any | (in_origin == cfg_origin);
    // Intake never looks at out_ready, so a full buffer blocks even when a pop is pending.
    assign in_yumi = in_valid & ~full_r & ~rst;
    assign push_s  = in_yumi & match_s;
    assign pop_s   = ~empty_r & out_ready;

    assign head_s     = mem_r[rd_ptr_r];
    assign out_valid  = ~empty_r;
    assign out_data   = head_s[DATA_W-1:0];
    assign out_origin = head_s[ENTRY_W-1:DATA_W];
    assign level      = level_r;
    assign full       = full_r;
    assign empty      = empty_r;

    // Next occupancy from the push/pop pair.
    always_comb begin
        level_nxt_s = level_r;
        case ({push_s, pop_s})
            2'b10:   level_nxt_s = level_r + LVL_W'(1);
            2'b01:   level_nxt_s = level_r - LVL_W'(1);
            default: level_nxt_s = level_r;
        endcase
    end

    // Pointers, occupancy and registered full/empty flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            level_r  <= {LVL_W{1'b0}};
            full_r   <= 1'b0;
            empty_r  <= 1'b1;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            level_r <= level_nxt_s;
            full_r  <= (level_nxt_s == LVL_W'(DEPTH));
            empty_r <= (level_nxt_s == {LVL_W{1'b0}});
        end
    end

    // Storage is cleared on reset so the head reads as zero while empty.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {ENTRY_W{1'b0}};
            end
        end else if (push_s) begin
            mem_r[wr_ptr_r] <= {in_origin, in_data};
        end
    end

`ifdef MPI_RECV_BUFFER_STATS_EN
    logic             drop_s;
    logic [CNT_W-1:0] rx_cnt_r;
    logic [CNT_W-1:0] drop_cnt_r;

    assign drop_s     = in_yumi & ~match_s;
    assign rx_count   = rx_cnt_r;
    assign drop_count = drop_cnt_r;

    // Saturating statistics counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_cnt_r   <= {CNT_W{1'b0}};
            drop_cnt_r <= {CNT_W{1'b0}};
        end else begin
            if (push_s && (rx_cnt_r != {CNT_W{1'b1}})) begin
                rx_cnt_r <= rx_cnt_r + CNT_W'(1);
            end
            if (drop_s && (drop_cnt_r != {CNT_W{1'b1}})) begin
                drop_cnt_r <= drop_cnt_r + CNT_W'(1);
            end
        end
    end
`else
    assign rx_count   = {CNT_W{1'b0}};
    assign drop_count = {CNT_W{1'b0}};
`endif

endmodule

// File: doc/mpi_recv_buffer.md
Name: mpi_recv_buffer

Overview:
- Receive-side elastic buffer directly downstream of the MPI receiver stage.
- Consumes the receiver's valid/data/origin stream using the yumi handshake and stores accepted messages in a FIFO.
- Filters messages by source rank, or accepts any source.
- Presents buffered messages to the compute side over a valid/ready interface, decoupling DPI receive timing from consumer back-pressure.

Parameters:
- DATA_W, 64, message payload width in bits.
- ORIGIN_W, 32, source-rank field width.
- DEPTH, 8, FIFO entries; power of 2, minimum 2.
- CNT_W, 16, statistics counter width.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  receiver has a message available.
- in_data  input  DATA_W  receiver message payload.
- in_origin  input  ORIGIN_W  source rank of the message.
- in_yumi  output  1  message consumed this cycle; the receiver advances.
- cfg_origin  input  ORIGIN_W  expected source rank.
- cfg_any  input  1  when 1, accept messages from any source.
- out_valid  output  1  FIFO head valid.
- out_data  output  DATA_W  head payload.
- out_origin  output  ORIGIN_W  head source rank.
- out_ready  input  1  consumer takes the head when out_valid is also 1.
- level  output  $clog2(DEPTH)+1  current occupancy.
- full  output  1  level == DEPTH.
- empty  output  1  level == 0.
- rx_count  output  CNT_W  messages written to the FIFO (stats).
- drop_count  output  CNT_W  messages discarded by the filter (stats).

Behaviour:
- Reset (async assert, synchronous-to-clk effect on deassert):
  - Read and write pointers = 0; level = 0; empty = 1; full = 0.
  - out_valid = 0; out_data and out_origin = 0; rx_count and drop_count = 0.
  - in_yumi forced to 0 while rst is high.
- Handshake with the receiver:
  - in_yumi = in_valid & ~full & ~rst, purely combinational.
  - No dependency on out_ready, so no combinational path from out_ready to in_yumi.
  - in_yumi is never 1 when in_valid is 0.
- Filter: let match = cfg_any | (in_origin == cfg_origin).
  - On in_yumi & match, write {in_origin, in_data} at the write pointer.
  - On in_yumi & ~match, consume and discard: no write, drop_count increments.
  - A mismatching message is still consumed only when not full, so receiver ordering is preserved.
- Output:
  - First-word-fall-through: out_valid = ~empty; out_data and out_origin show the head entry.
  - Pop on out_valid & out_ready.
  - Latency: a message accepted at edge N is visible on out_valid after edge N (one cycle).
  - No same-cycle bypass.
- Simultaneous push and pop:
  - level unchanged; both pointers advance.
  - Allowed at any level except empty, where only the push takes effect.
  - When full, the push is blocked (in_yumi = 0) even if a pop occurs in the same cycle.
- Pointer arithmetic:
  - Pointers are $clog2(DEPTH) bits and wrap naturally at DEPTH.
  - level is updated +1, -1 or 0 per cycle.
  - full and empty are registered from the next-state level.
- Counters: rx_count and drop_count saturate at all-ones and do not wrap.
- Holding the head:
  - out_data and out_origin stay stable while out_valid = 1 and out_ready = 0.
  - Changes to cfg_origin or cfg_any do not affect entries already stored.
- Reset mid-operation: all buffered entries are discarded and out_valid drops to 0 immediately (asynchronously).

Optional Feature:
- Macro: MPI_RECV_BUFFER_STATS_EN.
- Defined: rx_count and drop_count are implemented as saturating counters, as described above.
- Undefined:
  - The counter registers are not built; rx_count and drop_count are tied to 0.
  - Filtering and drop behaviour are otherwise identical.

Test Plan:
- Reset mid-stream: push 3 messages, then pulse rst for 1 ns mid-cycle. Expect out_valid = 0, level = 0, empty = 1 immediately, and in_yumi = 0 while rst is high.
- In-order delivery: cfg_any = 1, out_ready = 0; push data 0x11, 0x22, 0x33 with origin 1. Expect level = 3. Then set out_ready = 1: pops 0x11, 0x22, 0x33 in order, each with origin 1.
- Fill to full: DEPTH = 8, out_ready = 0, in_valid held high for 10 cycles. Expect in_yumi high for exactly 8 cycles, then full = 1, in_yumi = 0, level = 8.
- Push/pop when full: at full, set out_ready = 1 with in_valid = 1. Expect cycle 1 pops only (level 7), then steady streaming at level 7 with one push and one pop per cycle.
- Origin filter: cfg_any = 0, cfg_origin = 1; send origins 0, 1, 2, 1 with data 0xA0..0xA3. Expect all four consumed, only 0xA1 and 0xA3 delivered, drop_count = 2 and rx_count = 2 (stats build), or both counters 0 (non-stats build).
- Pointer wrap-around: stream 20 messages with out_ready toggling 1010…; data is an incrementing counter starting at 0. Expect output 0..19 in order with no loss or duplication across pointer wrap.
